// File: rtl/output_link_credit_control_unit_pkg.sv
// Shared constants, sizing helper and FSM encoding for the output link credit control unit.
package output_link_credit_control_unit_pkg;

  localparam int unsigned DATA_FLITS   = 4;
  localparam int unsigned BUFFER_DEPTH = 20;

  // Bits needed to index 0..value-1 (never less than one).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) width = i + 1;
    end
    return (width == 0) ? 1 : width;
  endfunction

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } link_state_e;

endpackage

// File: rtl/output_link_credit_control_unit_credit_counter.sv
// Saturating packet-credit counter for one output link; flags returned-credit overflow.
module output_link_credit_control_unit_credit_counter
  import output_link_credit_control_unit_pkg::*;
#(
  parameter int unsigned  MAX_CREDITS = BUFFER_DEPTH / (DATA_FLITS + 1),
  localparam int unsigned CRD_WIDTH   = clog2(MAX_CREDITS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 consume,
  input  logic                 credit_in,
  output logic [CRD_WIDTH-1:0] count,
  output logic                 nonzero_c,
  output logic                 overflow_error
);

  localparam logic [CRD_WIDTH-1:0] FULL = CRD_WIDTH'(MAX_CREDITS);

  // Simultaneous consume and return cancel out, so only the single-sided cases move the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      count          <= FULL;
      overflow_error <= 1'b0;
    end else begin
      case ({consume, credit_in})
        2'b10: count <= count - CRD_WIDTH'(1);
        2'b01: begin
          if (count == FULL) overflow_error <= 1'b1;
          else               count          <= count + CRD_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  assign nonzero_c = (count != '0);

endmodule

// File: rtl/output_link_credit_control_unit.sv
// Output-port control: grants the routed input a packet slot, frames the flits and spends one credit per packet.
module output_link_credit_control_unit
  import output_link_credit_control_unit_pkg::*;
#(
  parameter int unsigned  PKT_FLITS   = DATA_FLITS + 1,
  parameter int unsigned  MAX_CREDITS = BUFFER_DEPTH / PKT_FLITS,
  localparam int unsigned CNT_WIDTH   = clog2(PKT_FLITS),
  localparam int unsigned CRD_WIDTH   = clog2(MAX_CREDITS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 request_din,
  input  logic                 credit_in_din,
  output logic                 transfer_strobe_dout,
  output logic                 port_ready_dout,
  output logic                 flit_valid_dout,
  output logic                 tail_flit_dout,
  output logic [CRD_WIDTH-1:0] credit_count_dout,
  output logic                 credit_error_dout
);

  localparam logic [CNT_WIDTH-1:0] FLIT_RELOAD = CNT_WIDTH'(PKT_FLITS - 1);
  localparam logic                 SINGLE_FLIT = (PKT_FLITS == 1);

  link_state_e          state;
  logic [CNT_WIDTH-1:0] flit_cnt;
  logic                 grant_c;
  logic                 credit_nonzero_c;

  assign grant_c = (state == IDLE) && request_din && credit_nonzero_c;

  output_link_credit_control_unit_credit_counter #(
    .MAX_CREDITS(MAX_CREDITS)
  ) u_credit_counter (
    .clk           (clk),
    .reset         (reset),
    .consume       (grant_c),
    .credit_in     (credit_in_din),
    .count         (credit_count_dout),
    .nonzero_c     (credit_nonzero_c),
    .overflow_error(credit_error_dout)
  );

  // Packet framing: flit counter runs down from PKT_FLITS-1; zero marks the tail cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      flit_cnt             <= FLIT_RELOAD;
      transfer_strobe_dout <= 1'b0;
      flit_valid_dout      <= 1'b0;
      tail_flit_dout       <= 1'b0;
    end else begin
      transfer_strobe_dout <= grant_c;
      case (state)
        IDLE: begin
          if (grant_c) begin
            state           <= ACTIVE;
            flit_valid_dout <= 1'b1;
            tail_flit_dout  <= SINGLE_FLIT;
          end
        end
        ACTIVE: begin
          if (flit_cnt == '0) begin
            state           <= IDLE;
            flit_cnt        <= FLIT_RELOAD;
            flit_valid_dout <= 1'b0;
            tail_flit_dout  <= 1'b0;
          end else begin
            flit_cnt       <= flit_cnt - CNT_WIDTH'(1);
            tail_flit_dout <= (flit_cnt == CNT_WIDTH'(1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign port_ready_dout = (state == IDLE) && credit_nonzero_c;

endmodule

// File: tb/tb_output_link_credit_control_unit.sv
// Directed bench for output_link_credit_control_unit (PKT_FLITS=5, MAX_CREDITS=4).
module tb_output_link_credit_control_unit;

  logic       clk;
  logic       reset;
  logic       request_din;
  logic       credit_in_din;
  logic       transfer_strobe_dout;
  logic       port_ready_dout;
  logic       flit_valid_dout;
  logic       tail_flit_dout;
  logic [2:0] credit_count_dout;
  logic       credit_error_dout;

  int n_cmp = 0;
  int n_bad = 0;
  int strobes;
  int first_strobe;
  int last_strobe;

  output_link_credit_control_unit dut (
    .clk                 (clk),
    .reset               (reset),
    .request_din         (request_din),
    .credit_in_din       (credit_in_din),
    .transfer_strobe_dout(transfer_strobe_dout),
    .port_ready_dout     (port_ready_dout),
    .flit_valid_dout     (flit_valid_dout),
    .tail_flit_dout      (tail_flit_dout),
    .credit_count_dout   (credit_count_dout),
    .credit_error_dout   (credit_error_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check the full output vector: strobe, flit_valid, tail, ready, count, error.
  task automatic chk_all(input string tag, input logic s, input logic v, input logic t,
                         input logic r, input logic [2:0] c, input logic e);
    chk({tag, ".strobe"}, 32'(transfer_strobe_dout), 32'(s));
    chk({tag, ".valid"},  32'(flit_valid_dout),      32'(v));
    chk({tag, ".tail"},   32'(tail_flit_dout),       32'(t));
    chk({tag, ".ready"},  32'(port_ready_dout),      32'(r));
    chk({tag, ".count"},  32'(credit_count_dout),    32'(c));
    chk({tag, ".error"},  32'(credit_error_dout),    32'(e));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    request_din   = 1'b0;
    credit_in_din = 1'b0;
    tick(1);
    do_reset();
    chk_all("reset", 0, 0, 0, 1, 3'd4, 0);
    tick(2);
    chk_all("idle_no_req", 0, 0, 0, 1, 3'd4, 0);

    // Single packet
    request_din = 1'b1;
    tick(1);
    request_din = 1'b0;
    chk_all("pkt_t1", 1, 1, 0, 0, 3'd3, 0);
    tick(1);
    chk_all("pkt_t2", 0, 1, 0, 0, 3'd3, 0);
    tick(2);
    chk_all("pkt_t4", 0, 1, 0, 0, 3'd3, 0);
    tick(1);
    chk_all("pkt_t5", 0, 1, 1, 0, 3'd3, 0);
    tick(1);
    chk_all("pkt_t6", 0, 0, 0, 1, 3'd3, 0);

    // Credit exhaustion from full credits with request held
    do_reset();
    request_din  = 1'b1;
    strobes      = 0;
    first_strobe = -1;
    last_strobe  = -1;
    for (int i = 1; i <= 30; i++) begin
      tick(1);
      if (transfer_strobe_dout) begin
        strobes++;
        if (first_strobe < 0) first_strobe = i;
        last_strobe = i;
      end
    end
    chk("exhaust.strobes", 32'(strobes), 32'd4);
    chk("exhaust.first", 32'(first_strobe), 32'd1);
    chk("exhaust.last", 32'(last_strobe), 32'd19);
    chk_all("exhaust.end", 0, 0, 0, 0, 3'd0, 0);

    // Credit return from zero with request still pending
    credit_in_din = 1'b1;
    tick(1);
    credit_in_din = 1'b0;
    chk_all("ret_x1", 0, 0, 0, 1, 3'd1, 0);
    tick(1);
    request_din = 1'b0;
    chk_all("ret_x2", 1, 1, 0, 0, 3'd0, 0);
    tick(5);
    chk_all("ret_idle", 0, 0, 0, 0, 3'd0, 0);

    // Simultaneous consume and credit return at count 2
    credit_in_din = 1'b1;
    tick(2);
    chk("sim.pre", 32'(credit_count_dout), 32'd2);
    request_din = 1'b1;
    tick(1);
    request_din   = 1'b0;
    credit_in_din = 1'b0;
    chk_all("sim.grant", 1, 1, 0, 0, 3'd2, 0);
    tick(5);
    chk_all("sim.idle", 0, 0, 0, 1, 3'd2, 0);

    // Overflow: return beyond full
    credit_in_din = 1'b1;
    tick(2);
    credit_in_din = 1'b0;
    chk_all("ovf.full", 0, 0, 0, 1, 3'd4, 0);
    credit_in_din = 1'b1;
    tick(1);
    credit_in_din = 1'b0;
    chk_all("ovf.set", 0, 0, 0, 1, 3'd4, 1);
    tick(3);
    chk_all("ovf.held", 0, 0, 0, 1, 3'd4, 1);
    do_reset();
    chk_all("ovf.cleared", 0, 0, 0, 1, 3'd4, 0);

    // Reset during the third flit_valid cycle
    request_din = 1'b1;
    tick(1);
    request_din = 1'b0;
    tick(2);
    chk_all("mid.t3", 0, 1, 0, 0, 3'd3, 0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk_all("mid.abort", 0, 0, 0, 1, 3'd4, 0);
    tick(3);
    chk_all("mid.idle", 0, 0, 0, 1, 3'd4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
